// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 input vectors of a 4-input boolean circuit, captures its E/F outputs
// into truth tables, and flags any difference from the expected tables.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] exp_e,
  input  logic [15:0] exp_f,
  input  logic        e_in,
  input  logic        f_in,
  output logic        a_out,
  output logic        b_out,
  output logic        c_out,
  output logic        d_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_e,
  output logic [15:0] table_f,
  output logic        mismatch
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle_cycles
    $error("truth_table_sweeper: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q;
  logic [3:0]  vec_q;
  logic [15:0] exp_e_q, exp_f_q;
  logic [15:0] cap_e, cap_f;
  logic        busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          idx_d   = 4'd0;
        end
      end
      SETTLE: begin
        if (cnt_q == LAST_CNT) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (idx_q == 4'hF) begin
          state_d = DONE;
        end else begin
          state_d = SETTLE;
          idx_d   = idx_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tables with the current vector's bit replaced, so the final compare sees the last capture.
  always_comb begin
    cap_e        = table_e;
    cap_f        = table_f;
    cap_e[idx_q] = e_in;
    cap_f[idx_q] = f_in;
  end

  assign busy_d = (state_d == SETTLE) || (state_d == CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= 4'd0;
      cnt_q    <= 4'd0;
      vec_q    <= 4'd0;
      exp_e_q  <= 16'd0;
      exp_f_q  <= 16'd0;
      table_e  <= 16'd0;
      table_f  <= 16'd0;
      mismatch <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      idx_q <= idx_d;
      busy  <= busy_d;
      done  <= (state_d == DONE);
      vec_q <= busy_d ? idx_d : 4'd0;
      case (state_q)
        IDLE: begin
          if (start) begin
            exp_e_q  <= exp_e;
            exp_f_q  <= exp_f;
            table_e  <= 16'd0;
            table_f  <= 16'd0;
            mismatch <= 1'b0;
            cnt_q    <= 4'd0;
          end
        end
        SETTLE: cnt_q <= cnt_q + 4'd1;
        CAPTURE: begin
          table_e <= cap_e;
          table_f <= cap_f;
          cnt_q   <= 4'd0;
          if (idx_q == 4'hF)
            mismatch <= (cap_e != exp_e_q) || (cap_f != exp_f_q);
        end
        default: ;
      endcase
    end
  end

  assign a_out = vec_q[3];
  assign b_out = vec_q[2];
  assign c_out = vec_q[1];
  assign d_out = vec_q[0];

endmodule
